// File: rtl/avalon_user_rd_fifo_if.sv
// Host-side Avalon-MM CSR port plus user-side conduit read port of the
// host-to-user FIFO, bundled so the block and its users share one port list.
interface avalon_user_rd_fifo_if #(
    parameter int DATA_WIDTH = 32
) ();
    logic [1:0]            avs_address;
    logic                  avs_write;
    logic [31:0]           avs_writedata;
    logic                  avs_read;
    logic [31:0]           avs_readdata;
    logic                  user_rdreq;
    logic [DATA_WIDTH-1:0] user_data;
    logic                  user_valid;
    logic                  user_flag_0;
    logic                  user_flag_1;

    modport slave (
        input  avs_address, avs_write, avs_writedata, avs_read, user_rdreq,
        output avs_readdata, user_data, user_valid, user_flag_0, user_flag_1
    );

    modport master (
        output avs_address, avs_write, avs_writedata, avs_read, user_rdreq,
        input  avs_readdata, user_data, user_valid, user_flag_0, user_flag_1
    );
endinterface

// File: rtl/avalon_user_rd_fifo.sv
// Avalon-MM slave queueing host-written words into a RAM FIFO that user logic
// drains over a conduit port with a registered, one-cycle-latency output.
module avalon_user_rd_fifo #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_LOG2  = 8
) (
    input logic                  clk,
    input logic                  reset_n,
    avalon_user_rd_fifo_if.slave bus
);
    localparam int DEPTH = 1 << ADDR_LOG2;
    localparam int LVL_W = ADDR_LOG2 + 1;

    localparam logic [1:0] ADDR_DATA    = 2'd0;
    localparam logic [1:0] ADDR_STATUS  = 2'd1;
    localparam logic [1:0] ADDR_CONTROL = 2'd2;
    localparam logic [1:0] ADDR_DROPS   = 2'd3;

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [ADDR_LOG2-1:0]  wr_ptr_q, rd_ptr_q;
    logic [LVL_W-1:0]      level_q, level_nxt;
    logic                  empty_q, full_q;
    logic [15:0]           drops_q;

    logic [DATA_WIDTH-1:0] data_p1;
    logic                  vld_p1;
    logic [31:0]           rdata_p1;

    logic                  push_req, push_ok, pop_ok, flush, drop_inc, drop_clr;
    logic [DATA_WIDTH-1:0] push_word;
    logic [31:0]           rdata_nxt;

    // Request decode; a flush cancels any pop in the same cycle.
    assign push_req  = bus.avs_write && (bus.avs_address == ADDR_DATA);
    assign flush     = bus.avs_write && (bus.avs_address == ADDR_CONTROL) && bus.avs_writedata[0];
    assign drop_clr  = bus.avs_write && (bus.avs_address == ADDR_DROPS);
    assign push_ok   = push_req && !full_q;
    assign drop_inc  = push_req && full_q;
    assign pop_ok    = bus.user_rdreq && !empty_q && !flush;
    assign push_word = DATA_WIDTH'(bus.avs_writedata);

    always_comb begin
        level_nxt = level_q;
        case ({push_ok, pop_ok})
            2'b10:   level_nxt = level_q + LVL_W'(1);
            2'b01:   level_nxt = level_q - LVL_W'(1);
            default: level_nxt = level_q;
        endcase
    end

    always_comb begin
        rdata_nxt = '0;
        case (bus.avs_address)
            ADDR_STATUS: begin
                rdata_nxt[0]           = empty_q;
                rdata_nxt[1]           = full_q;
                rdata_nxt[16 +: LVL_W] = level_q;
            end
            ADDR_DROPS: rdata_nxt[15:0] = drops_q;
            default:    rdata_nxt = '0;
        endcase
    end

    // Storage: contents are not reset, a flush only rewinds the pointers.
    always_ff @(posedge clk) begin
        if (push_ok) mem[wr_ptr_q] <= push_word;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
            empty_q  <= 1'b1;
            full_q   <= 1'b0;
        end else if (flush) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
            empty_q  <= 1'b1;
            full_q   <= 1'b0;
        end else begin
            if (push_ok) wr_ptr_q <= wr_ptr_q + ADDR_LOG2'(1);
            if (pop_ok)  rd_ptr_q <= rd_ptr_q + ADDR_LOG2'(1);
            level_q <= level_nxt;
            empty_q <= (level_nxt == '0);
            full_q  <= (level_nxt == LVL_W'(DEPTH));
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)      drops_q <= '0;
        else if (drop_clr) drops_q <= '0;
        else if (drop_inc) drops_q <= sat_inc16(drops_q);
    end

    // Output stage p1: popped word, its valid pulse and the CSR read data.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            data_p1  <= '0;
            vld_p1   <= 1'b0;
            rdata_p1 <= '0;
        end else begin
            vld_p1 <= pop_ok;
            if (pop_ok) data_p1 <= mem[rd_ptr_q];
            rdata_p1 <= bus.avs_read ? rdata_nxt : 32'd0;
        end
    end

    assign bus.user_data    = data_p1;
    assign bus.user_valid   = vld_p1;
    assign bus.avs_readdata = rdata_p1;
    assign bus.user_flag_0  = empty_q;
    assign bus.user_flag_1  = full_q;
endmodule
